// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared state encoding and constants for the stall controller
package hazard_stall_controller_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MULT = 1'b1
  } ctrlState_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         CNT_W_DEF = 16;

  // A load in EX whose destination feeds the ID instruction; r0 is hardwired and never hazards.
  function automatic logic loadUseHit(input logic memRead, input logic [4:0] exRt,
                                      input logic [4:0] idRs, input logic [4:0] idRt);
    return memRead && (exRt != REG_ZERO) && ((exRt == idRs) || (exRt == idRt));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - pipeline hazard inputs and stage control outputs
interface hazard_stall_controller_if
  import hazard_stall_controller_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegRt;
  logic [4:0]       IF_ID_RegRs;
  logic [4:0]       IF_ID_RegRt;
  logic             EX_BranchTaken;
  logic             ID_EX_MultStart;
  logic             MEM_Wait;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Flush;
  logic             EX_MEM_Write;
  logic             EX_MEM_Flush;
  logic             MEM_WB_Flush;
  logic             Mult_Busy;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  modport master (
    output ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt,
           EX_BranchTaken, ID_EX_MultStart, MEM_Wait,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, Mult_Busy,
           Stall_Count, Flush_Count
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt,
           EX_BranchTaken, ID_EX_MultStart, MEM_Wait,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, Mult_Busy,
           Stall_Count, Flush_Count
  );
endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// rtl/hazard_stall_controller_sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - 5-stage pipeline write-enable/flush sequencing with stall statistics
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic                     clk,
  input logic                     reset,
  hazard_stall_controller_if.slave bus
);

  // Entry cycle is itself a stall, so the counter starts two below the occupancy.
  localparam logic [3:0] MULT_LOAD = (MULT_CYCLES > 1) ? 4'(MULT_CYCLES - 2) : 4'd0;

  ctrlState_t state, nextState;
  logic [3:0] multCnt, nextMultCnt;
  logic       loadUse, branchFlush;
  logic       pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush;
  logic       exMemWrite, exMemFlush, memWbFlush;

  assign loadUse = loadUseHit(bus.ID_EX_MemRead, bus.ID_EX_RegRt, bus.IF_ID_RegRs, bus.IF_ID_RegRt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      multCnt <= 4'd0;
    end else begin
      state   <= nextState;
      multCnt <= nextMultCnt;
    end
  end

  always_comb begin
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExWrite   = 1'b1;
    idExFlush   = 1'b0;
    exMemWrite  = 1'b1;
    exMemFlush  = 1'b0;
    memWbFlush  = 1'b0;
    branchFlush = 1'b0;
    nextState   = state;
    nextMultCnt = multCnt;

    if (reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
      ifIdFlush  = 1'b1;
      idExFlush  = 1'b1;
      exMemFlush = 1'b1;
      memWbFlush = 1'b1;
      nextState  = RUN;
      nextMultCnt = 4'd0;
    end else if (bus.MEM_Wait) begin
      // Full freeze; branch/load-use re-evaluate once memory is ready.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
      memWbFlush = 1'b1;
    end else if (state == MULT) begin
      if (multCnt != 4'd0) begin
        pcWrite     = 1'b0;
        ifIdWrite   = 1'b0;
        idExWrite   = 1'b0;
        exMemFlush  = 1'b1;
        nextMultCnt = multCnt - 4'd1;
      end else begin
        nextState = RUN;
      end
    end else if (bus.ID_EX_MultStart && (MULT_CYCLES > 1)) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemFlush  = 1'b1;
      nextMultCnt = MULT_LOAD;
      nextState   = MULT;
    end else if (bus.EX_BranchTaken) begin
      ifIdFlush   = 1'b1;
      idExFlush   = 1'b1;
      branchFlush = 1'b1;
    end else if (loadUse) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
    end
  end

  assign bus.PC_Write     = pcWrite;
  assign bus.IF_ID_Write  = ifIdWrite;
  assign bus.IF_ID_Flush  = ifIdFlush;
  assign bus.ID_EX_Write  = idExWrite;
  assign bus.ID_EX_Flush  = idExFlush;
  assign bus.EX_MEM_Write = exMemWrite;
  assign bus.EX_MEM_Flush = exMemFlush;
  assign bus.MEM_WB_Flush = memWbFlush;
  assign bus.Mult_Busy    = (state == MULT);

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (!pcWrite),
    .count (bus.Stall_Count)
  );

  sat_counter #(.W(CNT_W)) flushCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (branchFlush),
    .count (bus.Flush_Count)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed vector bench for hazard_stall_controller
module tb_hazard_stall_controller;
  import hazard_stall_controller_pkg::*;

  localparam int CNT_W = 16;

  // Control vector order: PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, EXMEM_F, MEMWB_F
  localparam logic [7:0] C_DEF   = 8'b1101_0100;
  localparam logic [7:0] C_LU    = 8'b0001_1100;
  localparam logic [7:0] C_BR    = 8'b1111_1100;
  localparam logic [7:0] C_WAIT  = 8'b0000_0001;
  localparam logic [7:0] C_MULT  = 8'b0000_0110;
  localparam logic [7:0] C_RESET = 8'b0010_1011;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [CNT_W-1:0] expStall = '0;
  logic [CNT_W-1:0] expFlush = '0;

  always #5 clk = ~clk;

  hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_controller #(.MULT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] ctrlVec;
  assign ctrlVec = {bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Write,
                    bus.ID_EX_Flush, bus.EX_MEM_Write, bus.EX_MEM_Flush, bus.MEM_WB_Flush};

  typedef struct {
    logic       memRead;
    logic [4:0] exRt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       branch;
    logic       memWait;
    logic [7:0] expCtrl;
    logic       stallInc;
    logic       flushInc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic memRead, input logic [4:0] exRt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic branch, input logic mult, input logic memWait);
    bus.ID_EX_MemRead   = memRead;
    bus.ID_EX_RegRt     = exRt;
    bus.IF_ID_RegRs     = rs;
    bus.IF_ID_RegRt     = rt;
    bus.EX_BranchTaken  = branch;
    bus.ID_EX_MultStart = mult;
    bus.MEM_Wait        = memWait;
  endtask

  // Entered at posedge+1: drive, check controls at negedge, advance one edge, check counters.
  task automatic step(input string name, input logic memRead, input logic [4:0] exRt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic branch,
                      input logic mult, input logic memWait, input logic [7:0] expCtrl,
                      input logic expBusy, input logic stallInc, input logic flushInc);
    drive(memRead, exRt, rs, rt, branch, mult, memWait);
    #4;
    check({name, ".ctrl"}, 32'(ctrlVec), 32'(expCtrl));
    check({name, ".busy"}, 32'(bus.Mult_Busy), 32'(expBusy));
    if (stallInc && expStall != '1) expStall = expStall + 1'b1;
    if (flushInc && expFlush != '1) expFlush = expFlush + 1'b1;
    @(posedge clk);
    #1;
    check({name, ".stall"}, 32'(bus.Stall_Count), 32'(expStall));
    check({name, ".flush"}, 32'(bus.Flush_Count), 32'(expFlush));
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      #4;
      check("reset.ctrl", 32'(ctrlVec), 32'(C_RESET));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    expStall = '0;
    expFlush = '0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, C_LU,   1'b1, 1'b0};
    vecs[2] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, C_LU,   1'b1, 1'b0};
    vecs[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_DEF,  1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd5, 5'd6, 5'd4, 1'b0, 1'b0, C_DEF,  1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd9, 5'd9, 5'd3, 1'b1, 1'b0, C_BR,   1'b0, 1'b1};
    vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_BR,   1'b0, 1'b1};
    vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_WAIT, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, C_WAIT, 1'b1, 1'b0};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    applyReset(2);
    step("post_reset", 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].memRead, vecs[i].exRt, vecs[i].rs, vecs[i].rt,
           vecs[i].branch, 1'b0, vecs[i].memWait, vecs[i].expCtrl, 1'b0,
           vecs[i].stallInc, vecs[i].flushInc);

    // Multiply: MultStart held high throughout to show it is ignored in MULT.
    step("mult_entry", 0, 0, 0, 0, 0, 1, 0, C_MULT, 0, 1, 0);
    step("mult_c2",    0, 0, 0, 0, 0, 1, 0, C_MULT, 1, 1, 0);
    step("mult_c1",    0, 0, 0, 0, 0, 1, 0, C_MULT, 1, 1, 0);
    step("mult_c0",    0, 0, 0, 0, 0, 1, 0, C_DEF,  1, 0, 0);
    step("mult_done",  0, 0, 0, 0, 0, 0, 0, C_DEF,  0, 0, 0);

    // MEM_Wait freezes MULT with mult_cnt=1.
    step("mw_entry", 0, 0, 0, 0, 0, 1, 0, C_MULT, 0, 1, 0);
    step("mw_c2",    0, 0, 0, 0, 0, 0, 0, C_MULT, 1, 1, 0);
    step("mw_wait0", 0, 0, 0, 0, 0, 0, 1, C_WAIT, 1, 1, 0);
    step("mw_wait1", 1, 4, 4, 0, 1, 0, 1, C_WAIT, 1, 1, 0);
    step("mw_c1",    1, 4, 4, 0, 1, 0, 0, C_MULT, 1, 1, 0);
    step("mw_c0",    1, 4, 4, 0, 1, 0, 0, C_DEF,  1, 0, 0);
    step("mw_run",   0, 0, 0, 0, 0, 0, 0, C_DEF,  0, 0, 0);

    // Reset in the middle of a multiply.
    step("rm_entry", 0, 0, 0, 0, 0, 1, 0, C_MULT, 0, 1, 0);
    step("rm_c2",    0, 0, 0, 0, 0, 0, 0, C_MULT, 1, 1, 0);
    applyReset(1);
    step("rm_after", 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0);

    // Saturation: 65534 wait cycles bring Stall_Count to 0xFFFE.
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (65534) @(posedge clk);
    #1;
    expStall = 16'hFFFE;
    check("sat.pre", 32'(bus.Stall_Count), 32'(expStall));
    step("sat0", 0, 0, 0, 0, 0, 0, 1, C_WAIT, 0, 1, 0);
    step("sat1", 0, 0, 0, 0, 0, 0, 1, C_WAIT, 0, 1, 0);
    step("sat2", 0, 0, 0, 0, 0, 0, 1, C_WAIT, 0, 1, 0);
    check("sat.final", 32'(bus.Stall_Count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage CPU. Generates per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves four conditions the forwarding path cannot cover: load-use hazards, taken-branch flushes, multi-cycle multiply occupancy of EX, and data-memory wait states. It also keeps saturating stall and flush statistics counters.

Parameters:
MULT_CYCLES, 4, total cycles a multiply occupies EX; legal range 1..16.
CNT_W, 16, width of the statistics counters.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_RegRt  input  5  destination register of the load in EX
IF_ID_RegRs  input  5  rs of the instruction in ID
IF_ID_RegRt  input  5  rt of the instruction in ID
EX_BranchTaken  input  1  branch in EX resolved taken
ID_EX_MultStart  input  1  instruction in EX is a multiply
MEM_Wait  input  1  data memory not ready for the access in MEM
PC_Write  output  1  PC load enable
IF_ID_Write  output  1  IF/ID load enable
IF_ID_Flush  output  1  IF/ID cleared to NOP
ID_EX_Write  output  1  ID/EX load enable
ID_EX_Flush  output  1  ID/EX cleared to bubble
EX_MEM_Write  output  1  EX/MEM load enable
EX_MEM_Flush  output  1  EX/MEM cleared to bubble
MEM_WB_Flush  output  1  MEM/WB cleared to bubble
Mult_Busy  output  1  controller in MULT state
Stall_Count  output  CNT_W  cycles with PC_Write=0, saturating
Flush_Count  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Registered state: FSM {RUN, MULT}, 4-bit mult_cnt, Stall_Count, Flush_Count. All control outputs are combinational from state and inputs, with zero latency.
- While reset=1:
  - All *_Write outputs are 0 and all *_Flush outputs are 1.
  - Next state is RUN, with mult_cnt=0 and both counters 0.
  - Reset mid-MULT aborts the multiply.
- Default (no condition active): all Write=1, all Flush=0.
- Priority, highest first: MEM_Wait > MULT occupancy > EX_BranchTaken > load-use.
- MEM_Wait=1 (any state):
  - PC, IF/ID, ID/EX and EX/MEM Write=0; MEM_WB_Flush=1.
  - FSM and mult_cnt hold.
  - Branch and load-use actions are suppressed. They re-evaluate when MEM_Wait drops, because the instructions are still in place.
- MULT entry: state RUN, ID_EX_MultStart=1, MULT_CYCLES>1, MEM_Wait=0.
  - PC, IF/ID and ID/EX Write=0; EX_MEM_Flush=1.
  - mult_cnt <= MULT_CYCLES-2; next state MULT.
  - If MULT_CYCLES=1, no stall occurs and the state stays RUN.
- MULT state:
  - mult_cnt!=0: same stall pattern as entry; decrement mult_cnt.
  - mult_cnt=0: default controls (multiply advances to MEM); next state RUN.
  - ID_EX_MultStart is ignored while in MULT.
  - Total EX occupancy is MULT_CYCLES cycles, of which MULT_CYCLES-1 are stall cycles.
- Taken branch (RUN, EX_BranchTaken=1, no higher condition):
  - IF_ID_Flush=1 and ID_EX_Flush=1; PC_Write=1 so the target is loaded.
  - Load-use in the same cycle is discarded, since the ID instruction is squashed.
- Load-use hazard: RUN, ID_EX_MemRead=1, ID_EX_RegRt!=0, and ID_EX_RegRt equals IF_ID_RegRs or IF_ID_RegRt.
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
  - Lasts exactly one cycle, because the load advances and the hazard clears naturally.
  - Register 0 never triggers a stall.
- Stall_Count: +1 on every non-reset cycle with PC_Write=0. Saturates at all-ones and never wraps.
- Flush_Count: +1 on every cycle the branch flush is applied. Saturates at all-ones.
- Mult_Busy=1 exactly when state=MULT.

Decomposition:
- Shared package: FSM state encoding (RUN=0, MULT=1), REG_ZERO=5'd0, CNT_W default.
- One sub-module, sat_counter (width parameter, inc, reset, saturating). It is instantiated twice for the statistics counters.

Test Plan:
- Reset held 2 cycles with random inputs -> all Write=0 and all Flush=1 during reset; after release, Write=1, Flush=0, Stall_Count=0, Flush_Count=0, Mult_Busy=0.
- ID_EX_MemRead=1, ID_EX_RegRt=5, IF_ID_RegRs=5 for one cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 in that cycle only; Stall_Count=1. Repeat with RegRt=0 -> no stall.
- ID_EX_MultStart=1 with MULT_CYCLES=4 -> 3 consecutive stall cycles with EX_MEM_Flush=1, then release; Mult_Busy high for 3 cycles; Stall_Count=3.
- EX_BranchTaken=1 together with a load-use match -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; Flush_Count=1; Stall_Count unchanged.
- MEM_Wait=1 for 2 cycles during MULT with mult_cnt=1 -> full freeze with MEM_WB_Flush=1, mult_cnt held at 1; after release, 1 more stall cycle then RUN; Stall_Count +3.
- Force Stall_Count to 0xFFFE, then apply 3 stall cycles -> reads 0xFFFF and stays there; reset mid-MULT -> next cycle state RUN, Mult_Busy=0.
